// File: rtl/coin_acceptor.sv
// coin_acceptor: measures synchronized coin-sensor pulse widths, classifies each
// coin into a currency code, queues accepted codes and strobes them out one at a
// time to the vending machine. Bad and jammed coins are returned via a reject strobe.
module coin_acceptor #(
   parameter int unsigned CURRENCIES = 8,
   parameter int unsigned PULSE_UNIT = 8,
   parameter int unsigned TOL        = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              i_rst_n,
   input  logic                              i_coin_sense,
   input  logic                              i_ready_to_receive,
   output logic [$clog2(CURRENCIES)-1:0]     o_currency_code,
   output logic                              o_currency_strobe,
   output logic                              o_reject_strobe,
   output logic                              o_jam,
   output logic                              o_accept_enable,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);

   localparam int unsigned MAX_PULSE = (CURRENCIES + 1) * PULSE_UNIT;
   localparam int unsigned WW        = $clog2(MAX_PULSE + 1);
   localparam int unsigned CW        = $clog2(CURRENCIES);
   localparam int unsigned NW        = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned AW        = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {WAIT_LOW, IDLE, MEASURE, JAM} state_t;

   state_t          state, state_next;
   logic            sync1, s;
   logic [1:0]      warm;
   logic [WW-1:0]   w, w_next;
   logic            fall_evt, jam_release;
   logic            cls_valid;
   logic [CW-1:0]   cls_code;
   logic            pop, push, reject;
   logic [NW-1:0]   count_next;
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   mem [FIFO_DEPTH];

   // Returns {valid, code} for a measured width; bands never overlap since PULSE_UNIT > 2*TOL.
   function automatic logic [CW:0] classify(input logic [WW-1:0] width);
      logic [CW:0]  r;
      int unsigned  nom;
      r = '0;
      for (int unsigned k = 0; k < CURRENCIES; k++) begin
         nom = (k + 1) * PULSE_UNIT;
         if ((32'(width) + TOL >= nom) && (32'(width) <= nom + TOL))
            r = {1'b1, CW'(k)};
      end
      return r;
   endfunction

   // Two-flop synchronizer; warm counts edges until s reflects post-reset sensor input.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         warm  <= 2'd0;
      end else begin
         sync1 <= i_coin_sense;
         s     <= sync1;
         if (warm != 2'd2)
            warm <= warm + 2'd1;
      end
   end

   // Measure FSM state and width counter registers.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state <= WAIT_LOW;
         w     <= '0;
      end else begin
         state <= state_next;
         w     <= w_next;
      end
   end

   // Measure FSM next state: width counting, fall detection, jam entry/exit.
   always_comb begin
      state_next  = state;
      w_next      = w;
      fall_evt    = 1'b0;
      jam_release = 1'b0;
      case (state)
         WAIT_LOW: begin
            if ((warm == 2'd2) && !s)
               state_next = IDLE;
         end
         IDLE: begin
            if (s) begin
               w_next     = WW'(1);
               state_next = MEASURE;
            end
         end
         MEASURE: begin
            if (s) begin
               if (w != WW'(MAX_PULSE))
                  w_next = w + WW'(1);
               if (w_next == WW'(MAX_PULSE))
                  state_next = JAM;
            end else begin
               fall_evt   = 1'b1;
               state_next = IDLE;
            end
         end
         JAM: begin
            if (!s) begin
               jam_release = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = WAIT_LOW;
      endcase
   end

   // Classification, handshake pop, FIFO push/reject decision and next count.
   always_comb begin
      {cls_valid, cls_code} = classify(w);
      pop    = (o_fifo_count != '0) && i_ready_to_receive && !o_currency_strobe;
      push   = fall_evt && cls_valid && ((o_fifo_count != NW'(FIFO_DEPTH)) || pop);
      reject = jam_release || (fall_evt && !push);
      count_next = o_fifo_count;
      if (push && !pop)
         count_next = o_fifo_count + NW'(1);
      else if (!push && pop)
         count_next = o_fifo_count - NW'(1);
   end

   // Registered outputs and FIFO pointers.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         o_currency_code   <= '0;
         o_currency_strobe <= 1'b0;
         o_reject_strobe   <= 1'b0;
         o_jam             <= 1'b0;
         o_accept_enable   <= 1'b1;
         o_fifo_count      <= '0;
         rd_ptr            <= '0;
         wr_ptr            <= '0;
      end else begin
         o_currency_strobe <= pop;
         o_reject_strobe   <= reject;
         o_jam             <= (state_next == JAM);
         o_fifo_count      <= count_next;
         o_accept_enable   <= (count_next < NW'(FIFO_DEPTH));
         if (pop) begin
            o_currency_code <= mem[rd_ptr];
            rd_ptr          <= rd_ptr + AW'(1);
         end
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
      end
   end

   // FIFO storage; contents are don't-care while the count is zero.
   always_ff @(posedge clk) begin
      if (i_rst_n && push)
         mem[wr_ptr] <= cls_code;
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: run-length reference model of the sensor, queue-based
// FIFO model, per-cycle output comparison plus directed literal expectations.
module tb_coin_acceptor;

   localparam int PULSE_UNIT = 8;
   localparam int TOL        = 2;
   localparam int CURRENCIES = 8;
   localparam int DEPTH      = 4;
   localparam int MAX_PULSE  = (CURRENCIES + 1) * PULSE_UNIT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sense = 1'b0;
   logic       ready = 1'b0;
   logic [2:0] code;
   logic       strobe, reject, jam, accept;
   logic [2:0] count;

   always #5 clk = ~clk;

   coin_acceptor dut (
      .clk                (clk),
      .i_rst_n            (rst_n),
      .i_coin_sense       (sense),
      .i_ready_to_receive (ready),
      .o_currency_code    (code),
      .o_currency_strobe  (strobe),
      .o_reject_strobe    (reject),
      .o_jam              (jam),
      .o_accept_enable    (accept),
      .o_fifo_count       (count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int  e_code = 0, e_strobe = 0, e_reject = 0, e_jam = 0, e_accept = 1, e_count = 0;
   int  q[$];
   int  codes[$];
   int  m_strobes = 0, m_rejects = 0;
   bit  s1 = 0, s2 = 0, s_now;
   int  since = 0;
   bit  armed = 0, jammed = 0, pop;
   int  run = 0, k;

   function automatic int code_of(input int width);
      for (int i = 0; i < CURRENCIES; i++)
         if (width >= (i + 1) * PULSE_UNIT - TOL && width <= (i + 1) * PULSE_UNIT + TOL)
            return i;
      return -1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         s1 = 0; s2 = 0; since = 0; armed = 0; jammed = 0; run = 0;
         q.delete();
         e_code = 0; e_strobe = 0; e_reject = 0; e_jam = 0; e_accept = 1; e_count = 0;
      end else begin
         s_now = s2;
         s2 = s1;
         s1 = sense;
         pop = (q.size() > 0) && ready && (e_strobe == 0);
         e_strobe = pop ? 1 : 0;
         if (pop) begin
            e_code = q.pop_front();
            codes.push_back(e_code);
            m_strobes++;
         end
         e_reject = 0;
         if (!armed) begin
            if (since >= 2 && !s_now) armed = 1;
            if (since < 2) since++;
         end else if (jammed) begin
            if (!s_now) begin jammed = 0; e_reject = 1; end
         end else if (s_now) begin
            run++;
            if (run >= MAX_PULSE) begin jammed = 1; run = 0; end
         end else if (run > 0) begin
            k = code_of(run);
            if (k >= 0 && q.size() < DEPTH) q.push_back(k);
            else e_reject = 1;
            run = 0;
         end
         if (e_reject != 0) m_rejects++;
         e_jam    = jammed ? 1 : 0;
         e_count  = q.size();
         e_accept = (q.size() < DEPTH) ? 1 : 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit prev_strobe = 0;
   always @(negedge clk) begin
      check("code",   int'(code),   e_code);
      check("strobe", int'(strobe), e_strobe);
      check("reject", int'(reject), e_reject);
      check("jam",    int'(jam),    e_jam);
      check("accept", int'(accept), e_accept);
      check("count",  int'(count),  e_count);
      if (strobe === 1'b1)
         check("strobe_spacing", int'(prev_strobe), 0);
      prev_strobe = (strobe === 1'b1);
   end

   // ---------------- stimulus ----------------
   bit rnd_ready = 0;

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         if (rnd_ready) ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic coin(input int width, input int gap);
      sense = 1'b1;
      step(width);
      sense = 1'b0;
      step(gap);
   endtask

   int s0, r0, w, r;

   initial begin
      @(negedge clk);
      rst_n = 1'b0; ready = 1'b1;
      step(3);
      check("rst_count", int'(count), 0);
      check("rst_accept", int'(accept), 1);
      check("rst_strobe", int'(strobe), 0);
      rst_n = 1'b1;
      step(4);

      // single valid coin
      s0 = m_strobes; r0 = m_rejects;
      coin(16, 6);
      check("single_strobes", m_strobes - s0, 1);
      check("single_code", codes[$], 1);
      check("single_rejects", m_rejects - r0, 0);
      check("single_count", int'(count), 0);

      // out of band
      s0 = m_strobes; r0 = m_rejects;
      coin(13, 6);
      check("oob_rejects", m_rejects - r0, 1);
      check("oob_strobes", m_strobes - s0, 0);

      // tolerance edges
      s0 = m_strobes; r0 = m_rejects;
      coin(6, 4); coin(10, 4); coin(5, 4); coin(11, 4);
      check("tol_strobes", m_strobes - s0, 2);
      check("tol_rejects", m_rejects - r0, 2);
      check("tol_code_a", codes[$-1], 0);
      check("tol_code_b", codes[$], 0);

      // full FIFO
      ready = 1'b0;
      s0 = m_strobes; r0 = m_rejects;
      repeat (5) coin(8, 3);
      check("full_count", int'(count), 4);
      check("full_accept", int'(accept), 0);
      check("full_rejects", m_rejects - r0, 1);
      ready = 1'b1;
      step(12);
      check("drain_strobes", m_strobes - s0, 4);
      for (int i = 0; i < 4; i++) check("drain_code", codes[codes.size() - 1 - i], 0);
      check("drain_accept", int'(accept), 1);

      // jam
      s0 = m_strobes; r0 = m_rejects;
      sense = 1'b1;
      step(80);
      check("jam_on", int'(jam), 1);
      step(20);
      sense = 1'b0;
      step(6);
      check("jam_off", int'(jam), 0);
      check("jam_rejects", m_rejects - r0, 1);
      check("jam_strobes", m_strobes - s0, 0);

      // reset mid-measure
      s0 = m_strobes; r0 = m_rejects;
      sense = 1'b1;
      step(5);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(10);
      sense = 1'b0;
      step(6);
      check("rstmid_strobes", m_strobes - s0, 0);
      check("rstmid_rejects", m_rejects - r0, 0);
      coin(24, 6);
      check("rstmid_next", codes[$], 2);
      check("rstmid_next_n", m_strobes - s0, 1);

      // ordering
      ready = 1'b0;
      coin(16, 3); coin(40, 3);
      ready = 1'b1;
      step(8);
      check("order_first", codes[$-1], 1);
      check("order_second", codes[$], 4);

      // randomized traffic
      rnd_ready = 1;
      for (int it = 0; it < 250; it++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)
            w = int'($urandom_range(1, 8)) * PULSE_UNIT + int'($urandom_range(0, 6)) - 3;
         else if (r < 9)
            w = int'($urandom_range(1, 80));
         else
            w = int'($urandom_range(73, 110));
         coin(w, int'($urandom_range(1, 5)));
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
         end
      end
      rnd_ready = 0;
      ready = 1'b1;
      step(20);
      check("final_count", int'(count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
